// File: rtl/bcd_display_converter.sv
// Binary-to-BCD converter for an eight-digit seven-segment display.
// Double-dabble over 27 cycles, with saturation at 99,999,999 and optional leading-zero blanking.
module bcd_display_converter #(
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [26:0] value,
  input  logic        blank_all,
  output logic        ready,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  BCD7,
  output logic [3:0]  BCD6,
  output logic [3:0]  BCD5,
  output logic [3:0]  BCD4,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic [7:0]  turn_on
);

  localparam logic [26:0] MaxVal = 27'd99_999_999;
  localparam logic [4:0]  LastIter = 5'd26;

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [58:0] sr_q, sr_d;
  logic        ovf_in_q, ovf_in_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  turn_on_q, turn_on_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [31:0] bcd_field;
  logic [31:0] bcd_adj;
  logic [58:0] pre_shift;
  logic [7:0]  turn_on_raw;
  logic        lead;

  assign bcd_field = sr_q[58:27];

  // Add-3 correction on every BCD nibble >= 5 before each left shift.
  always_comb begin
    bcd_adj = bcd_field;
    for (int i = 0; i < 8; i++) begin
      if (bcd_field[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_field[4*i +: 4] + 4'd3;
      end
    end
    pre_shift = {bcd_adj, sr_q[26:0]};
  end

  // A digit is lit if it or any more significant digit is nonzero; digit 0 always lit.
  always_comb begin
    lead        = 1'b0;
    turn_on_raw = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      lead           = lead | (bcd_field[4*i +: 4] != 4'd0);
      turn_on_raw[i] = lead;
    end
    turn_on_raw[0] = 1'b1;
    if (BLANK_LEADING == 0) begin
      turn_on_raw = 8'hFF;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ovf_in_d  = ovf_in_q;
    digits_d  = digits_q;
    turn_on_d = turn_on_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StConv;
          cnt_d    = 5'd0;
          ovf_in_d = (value > MaxVal);
          sr_d     = {32'b0, (value > MaxVal) ? MaxVal : value};
        end
      end
      StConv: begin
        sr_d  = pre_shift << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        digits_d  = bcd_field;
        turn_on_d = turn_on_raw;
        ovf_d     = ovf_in_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      sr_q      <= '0;
      ovf_in_q  <= 1'b0;
      digits_q  <= '0;
      turn_on_q <= 8'h00;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ovf_in_q  <= ovf_in_d;
      digits_q  <= digits_d;
      turn_on_q <= turn_on_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign turn_on  = blank_all ? 8'h00 : turn_on_q;
  assign BCD7     = digits_q[31:28];
  assign BCD6     = digits_q[27:24];
  assign BCD5     = digits_q[23:20];
  assign BCD4     = digits_q[19:16];
  assign BCD3     = digits_q[15:12];
  assign BCD2     = digits_q[11:8];
  assign BCD1     = digits_q[7:4];
  assign BCD0     = digits_q[3:0];

endmodule

// File: doc/bcd_display_converter.md
BCD_DISPLAY_CONVERTER -- requirements
Module: bcd_display_converter

Interface
REQ-001 SHALL have parameter: BLANK_LEADING, 1, nonzero = suppress leading-zero digits; 0 = all eight digits lit.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  1  conversion request; sampled only when ready=1.
REQ-005 SHALL have port: value  input  27  unsigned binary value to display; sampled with req.
REQ-006 SHALL have port: blank_all  input  1  forces turn_on to 0 (combinational, not registered).
REQ-007 SHALL have port: ready  output  1  high iff FSM is in IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when outputs update.
REQ-009 SHALL have port: overflow  output  1  registered; 1 = last accepted value exceeded 99,999,999.
REQ-010 SHALL have ports: BCD7..BCD0  output  4 each  registered decimal digits (BCD7 most significant), feeding the seven-segment control block.
REQ-011 SHALL have port: turn_on  output  8  per-digit enable (bit i enables digit i), feeding the seven-segment control block.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, LOAD; IDLE->CONV on req=1; CONV->LOAD after 27 shift cycles; LOAD->IDLE unconditionally.
REQ-013 SHALL, on accepting req (edge E0), load a 59-bit shift register with {32'b0, value'} and clear a 5-bit iteration counter, where value' = value, or 27'd99_999_999 if value > 99,999,999.
REQ-014 SHALL, on each CONV edge (E1..E27): add 3 to every BCD nibble >= 5, then shift the whole register left by 1; counter increments; on the edge where counter = 26, go to LOAD.
REQ-015 SHALL, on the LOAD edge (E28): register BCD7..BCD0 from the BCD field, register overflow, register turn_on_raw, and assert done for exactly the following cycle.
REQ-016 SHALL present updated BCD/turn_on/done 28 cycles after the accept edge; ready SHALL be 0 from the cycle after E0 through the cycle after E27, and 1 again from the cycle after E28.
REQ-017 SHALL ignore req while ready=0 (no queuing, no effect on value in flight).
REQ-018 SHALL permit back-to-back operation: req=1 in the cycle in which done=1 is accepted (ready=1 in that cycle).
REQ-019 SHALL hold BCD7..BCD0, turn_on_raw, and overflow stable between LOAD edges.
REQ-020 SHALL, with BLANK_LEADING nonzero, compute turn_on_raw bit i = 1 iff some digit j >= i is nonzero, with bit 0 always 1 (value 0 shows a single "0").
REQ-021 SHALL, with BLANK_LEADING = 0, compute turn_on_raw = 8'hFF.
REQ-022 SHALL drive turn_on = blank_all ? 8'h00 : turn_on_raw.
REQ-023 SHALL never present a BCD digit > 9 on any BCD output.

Reset
REQ-024 SHALL, when rst_n=0, asynchronously force: FSM = IDLE, counter = 0, shift register = 0, BCD7..BCD0 = 0, turn_on_raw = 8'h00, overflow = 0, done = 0.
REQ-025 SHALL abort any conversion in progress when reset is asserted, with no done pulse; ready SHALL be 1 while in reset.
REQ-026 SHALL leave the first accepted req after reset release unaffected by the aborted conversion.

Verification
REQ-027 Bench SHALL check: req with value=0 -> done 28 cycles later; BCD all 0; turn_on=8'h01; overflow=0.
REQ-028 Bench SHALL check: value=12345 -> BCD4..BCD0=1,2,3,4,5; BCD7..BCD5=0; turn_on=8'h1F; with blank_all=1, turn_on=8'h00 in the same cycle.
REQ-029 Bench SHALL check: value=99,999,999 -> all digits 9, turn_on=8'hFF, overflow=0; then value=100,000,000 -> all digits 9, overflow=1.
REQ-030 Bench SHALL check: req with value=42, then req with value=7 at cycle 10 while busy -> single done; BCD1,BCD0=4,2; ready low for exactly 28 cycles.
REQ-031 Bench SHALL check: rst_n low at cycle 15 of a conversion of 555 -> outputs return to reset values immediately; no done pulse; next req with value=9 -> BCD0=9, turn_on=8'h01.
REQ-032 Bench SHALL check: with BLANK_LEADING=0, value=42 -> turn_on=8'hFF, BCD7..BCD2=0.
